// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant state
// encoding, master indices and the round-robin pick helper.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  localparam logic M_I = 1'b0;
  localparam logic M_D = 1'b1;

  // Picks the next owner from the two requests; a tie goes to the master
  // that did not hold the bus last.
  function automatic state_e pick_grant(input logic i_req, input logic d_req,
                                        input logic last_grant);
    if (i_req && d_req) begin
      return (last_grant == M_I) ? GNT_D : GNT_I;
    end else if (i_req) begin
      return GNT_I;
    end else if (d_req) begin
      return GNT_D;
    end
    return IDLE;
  endfunction

endpackage

// File: rtl/wb_arbiter_watchdog.sv
// Bus watchdog: counts stalled strobe cycles of the current grant and
// raises a one-cycle fire pulse, registered, the cycle after the limit
// is reached. TW must be wide enough to hold TIMEOUT-1; TIMEOUT = 0
// turns the watchdog off.
module wb_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic done_i,
  input  logic clear_i,
  output logic fire_o
);

  localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT - 1);
  localparam bit            ENABLED    = (TIMEOUT != 0);

  logic [TW-1:0] count_q, count_d;
  logic          fire_q, fire_d;

  // Stall counting: ack/err or a grant change restart the count, a stalled
  // strobe advances it, and the final stalled cycle arms the fire pulse.
  always_comb begin
    count_d = count_q;
    fire_d  = 1'b0;
    if (clear_i || done_i) begin
      count_d = '0;
    end else if (active_i) begin
      if (ENABLED && (count_q == LAST_COUNT)) begin
        fire_d  = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Counter and fire pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      fire_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      fire_q  <= fire_d;
    end
  end

  assign fire_o = fire_q;

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter. The registered state is
// the grant; the slave side is muxed combinationally from it. A watchdog
// terminates transfers the slave never answers.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iwbm_addr_i,
  input  logic [31:0] iwbm_dat_i,
  input  logic [3:0]  iwbm_sel_i,
  input  logic        iwbm_cyc_i,
  input  logic        iwbm_stb_i,
  input  logic        iwbm_we_i,
  output logic [31:0] iwbm_dat_o,
  output logic        iwbm_ack_o,
  output logic        iwbm_err_o,
  input  logic [31:0] dwbm_addr_i,
  input  logic [31:0] dwbm_dat_i,
  input  logic [3:0]  dwbm_sel_i,
  input  logic        dwbm_cyc_i,
  input  logic        dwbm_stb_i,
  input  logic        dwbm_we_i,
  output logic [31:0] dwbm_dat_o,
  output logic        dwbm_ack_o,
  output logic        dwbm_err_o,
  output logic [31:0] wbs_addr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i,
  output logic        bus_timeout_o
);

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   term;
  logic   gnt_stb;
  logic   wd_active;

  assign gnt_stb   = ((state_q == GNT_I) & iwbm_stb_i) |
                     ((state_q == GNT_D) & dwbm_stb_i);
  assign wd_active = gnt_stb & ~term;

  wb_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .active_i(wd_active),
    .done_i  (wbs_ack_i | wbs_err_i),
    .clear_i (state_d != state_q),
    .fire_o  (term)
  );

  // Grant FSM: arbitrate from IDLE, hold while the owner keeps cyc, and on
  // release hand straight to the other master if it is waiting.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        state_d = pick_grant(iwbm_cyc_i, dwbm_cyc_i, last_grant_q);
      end
      GNT_I: begin
        if (term) begin
          state_d      = IDLE;
          last_grant_d = M_I;
        end else if (!iwbm_cyc_i) begin
          state_d      = pick_grant(1'b0, dwbm_cyc_i, M_I);
          last_grant_d = M_I;
        end
      end
      GNT_D: begin
        if (term) begin
          state_d      = IDLE;
          last_grant_d = M_D;
        end else if (!dwbm_cyc_i) begin
          state_d      = pick_grant(iwbm_cyc_i, 1'b0, M_D);
          last_grant_d = M_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant and fairness history registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= M_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Bus routing: the owner drives the slave and alone receives ack/err; a
  // watchdog termination blocks cyc/stb and any late ack and forces err.
  always_comb begin
    wbs_addr_o = '0;
    wbs_dat_o  = '0;
    wbs_sel_o  = '0;
    wbs_cyc_o  = 1'b0;
    wbs_stb_o  = 1'b0;
    wbs_we_o   = 1'b0;
    iwbm_ack_o = 1'b0;
    iwbm_err_o = 1'b0;
    dwbm_ack_o = 1'b0;
    dwbm_err_o = 1'b0;
    if (state_q == GNT_I) begin
      wbs_addr_o = iwbm_addr_i;
      wbs_dat_o  = iwbm_dat_i;
      wbs_sel_o  = iwbm_sel_i;
      wbs_we_o   = iwbm_we_i;
      wbs_cyc_o  = iwbm_cyc_i & ~term;
      wbs_stb_o  = iwbm_stb_i & ~term;
      iwbm_ack_o = wbs_ack_i & ~term;
      iwbm_err_o = wbs_err_i | term;
    end else if (state_q == GNT_D) begin
      wbs_addr_o = dwbm_addr_i;
      wbs_dat_o  = dwbm_dat_i;
      wbs_sel_o  = dwbm_sel_i;
      wbs_we_o   = dwbm_we_i;
      wbs_cyc_o  = dwbm_cyc_i & ~term;
      wbs_stb_o  = dwbm_stb_i & ~term;
      dwbm_ack_o = wbs_ack_i & ~term;
      dwbm_err_o = wbs_err_i | term;
    end
  end

  assign iwbm_dat_o    = wbs_dat_i;
  assign dwbm_dat_o    = wbs_dat_i;
  assign bus_timeout_o = term;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level
// model of the arbitration rules.
module tb_wb_arbiter;

  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]       m_cyc, m_stb, m_we;
  logic [1:0][31:0] m_addr, m_wdat;
  logic [1:0][3:0]  m_sel;

  logic [31:0] sl_rdat;
  logic        sl_ack, sl_err;

  logic [31:0] i_rdat, d_rdat, w_addr, w_wdat;
  logic [3:0]  w_sel;
  logic        i_ack, i_err, d_ack, d_err, w_cyc, w_stb, w_we, w_timeout;

  int checks = 0;
  int errors = 0;

  // model state: owner -1 none / 0 I / 1 D
  int  mdl_owner, mdl_last, mdl_wait;
  bit  mdl_term;

  typedef struct {
    logic [5:0]  stim;   // {i_cyc, i_stb, d_cyc, d_stb, ack, err}
    logic [31:0] rdat;
    logic [31:0] eaddr;
    logic [5:0]  expv;   // {cyc, we, i_ack, d_ack, i_err, d_err}
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TIMEOUT), .TW(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .iwbm_addr_i  (m_addr[0]),
    .iwbm_dat_i   (m_wdat[0]),
    .iwbm_sel_i   (m_sel[0]),
    .iwbm_cyc_i   (m_cyc[0]),
    .iwbm_stb_i   (m_stb[0]),
    .iwbm_we_i    (m_we[0]),
    .iwbm_dat_o   (i_rdat),
    .iwbm_ack_o   (i_ack),
    .iwbm_err_o   (i_err),
    .dwbm_addr_i  (m_addr[1]),
    .dwbm_dat_i   (m_wdat[1]),
    .dwbm_sel_i   (m_sel[1]),
    .dwbm_cyc_i   (m_cyc[1]),
    .dwbm_stb_i   (m_stb[1]),
    .dwbm_we_i    (m_we[1]),
    .dwbm_dat_o   (d_rdat),
    .dwbm_ack_o   (d_ack),
    .dwbm_err_o   (d_err),
    .wbs_addr_o   (w_addr),
    .wbs_dat_o    (w_wdat),
    .wbs_sel_o    (w_sel),
    .wbs_cyc_o    (w_cyc),
    .wbs_stb_o    (w_stb),
    .wbs_we_o     (w_we),
    .wbs_dat_i    (sl_rdat),
    .wbs_ack_i    (sl_ack),
    .wbs_err_i    (sl_err),
    .bus_timeout_o(w_timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] v, input logic [31:0] rdat);
    {m_cyc[0], m_stb[0], m_cyc[1], m_stb[1], sl_ack, sl_err} = v;
    sl_rdat = rdat;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic setMaster(input int m, input logic [31:0] addr,
                           input logic [31:0] wdat, input logic we);
    m_addr[m] = addr;
    m_wdat[m] = wdat;
    m_we[m]   = we;
    m_sel[m]  = 4'hF;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(6'b000000, 32'h0);
    stepClock();
    rst = 1'b0;
    #1;
  endtask

  function automatic int pickOwner(input logic ireq, input logic dreq, input int last);
    if (ireq && dreq) return 1 - last;
    if (ireq) return 0;
    if (dreq) return 1;
    return -1;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic modelStep();
    if (rst) begin
      mdl_owner = -1; mdl_last = 0; mdl_wait = 0; mdl_term = 1'b0;
    end else if (mdl_term) begin
      mdl_last = mdl_owner; mdl_owner = -1; mdl_term = 1'b0; mdl_wait = 0;
    end else if (mdl_owner < 0) begin
      mdl_owner = pickOwner(m_cyc[0], m_cyc[1], mdl_last);
      mdl_wait  = 0;
    end else if (!m_cyc[mdl_owner]) begin
      mdl_last  = mdl_owner;
      mdl_owner = m_cyc[1 - mdl_owner] ? 1 - mdl_owner : -1;
      mdl_wait  = 0;
    end else if (sl_ack || sl_err) begin
      mdl_wait = 0;
    end else if (m_stb[mdl_owner]) begin
      if (mdl_wait == TIMEOUT - 1) begin
        mdl_term = 1'b1;
        mdl_wait = 0;
      end else begin
        mdl_wait++;
      end
    end
  endtask

  task automatic modelCheck();
    logic        ecyc, estb;
    logic [31:0] eaddr;
    logic [1:0]  eack, eerr;
    ecyc = 1'b0; estb = 1'b0; eaddr = 32'h0; eack = 2'b00; eerr = 2'b00;
    if (mdl_owner >= 0) begin
      ecyc  = m_cyc[mdl_owner] & ~mdl_term;
      estb  = m_stb[mdl_owner] & ~mdl_term;
      eaddr = m_addr[mdl_owner];
      eack[mdl_owner] = sl_ack & ~mdl_term;
      eerr[mdl_owner] = sl_err | mdl_term;
    end
    checkOutput("rnd_cyc", w_cyc, ecyc);
    checkOutput("rnd_stb", w_stb, estb);
    checkOutput("rnd_addr", w_addr, eaddr);
    checkOutput("rnd_ack", {d_ack, i_ack}, eack);
    checkOutput("rnd_err", {d_err, i_err}, eerr);
    checkOutput("rnd_timeout", w_timeout, mdl_term);
    checkOutput("rnd_rdat", i_rdat, sl_rdat);
  endtask

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_wdat = '0; m_sel = '0;
    sl_rdat = '0; sl_ack = 1'b0; sl_err = 1'b0;
    stepClock();
    resetDut();

    // reset state
    checkOutput("reset_cyc", w_cyc, 1'b0);
    checkOutput("reset_stb", w_stb, 1'b0);
    checkOutput("reset_addr", w_addr, 32'h0);
    checkOutput("reset_wdat", w_wdat, 32'h0);
    checkOutput("reset_sel", w_sel, 4'h0);
    checkOutput("reset_we", w_we, 1'b0);
    checkOutput("reset_acks", {d_ack, i_ack, d_err, i_err}, 4'h0);
    checkOutput("reset_timeout", w_timeout, 1'b0);

    // directed vector table, applied from reset
    vecs[0]  = '{6'b000000, 32'h0,        32'h0,   6'b000000};
    vecs[1]  = '{6'b110000, 32'h0,        32'h0,   6'b000000};
    vecs[2]  = '{6'b110000, 32'h0,        32'h100, 6'b100000};
    vecs[3]  = '{6'b110000, 32'h0,        32'h100, 6'b100000};
    vecs[4]  = '{6'b110010, 32'h13,       32'h100, 6'b101000};
    vecs[5]  = '{6'b000000, 32'h0,        32'h100, 6'b000000};
    vecs[6]  = '{6'b000000, 32'h0,        32'h0,   6'b000000};
    vecs[7]  = '{6'b001100, 32'h0,        32'h0,   6'b000000};
    vecs[8]  = '{6'b111100, 32'h0,        32'h400, 6'b110000};
    vecs[9]  = '{6'b111101, 32'h0,        32'h400, 6'b110001};
    vecs[10] = '{6'b110000, 32'h0,        32'h400, 6'b010000};
    vecs[11] = '{6'b110000, 32'h0,        32'h100, 6'b100000};
    vecs[12] = '{6'b110011, 32'hDEADBEEF, 32'h100, 6'b101010};
    vecs[13] = '{6'b001100, 32'h0,        32'h100, 6'b000000};
    vecs[14] = '{6'b001100, 32'h0,        32'h400, 6'b110000};
    vecs[15] = '{6'b000000, 32'h0,        32'h400, 6'b010000};
    vecs[16] = '{6'b000000, 32'h0,        32'h0,   6'b000000};
    setMaster(0, 32'h100, 32'h0, 1'b0);
    setMaster(1, 32'h400, 32'h55AA, 1'b1);
    for (int v = 0; v < 17; v++) begin
      applyStimulus(vecs[v].stim, vecs[v].rdat);
      checkOutput($sformatf("vec%0d_cyc", v), w_cyc, vecs[v].expv[5]);
      checkOutput($sformatf("vec%0d_addr", v), w_addr, vecs[v].eaddr);
      checkOutput($sformatf("vec%0d_we", v), w_we, vecs[v].expv[4]);
      checkOutput($sformatf("vec%0d_acks", v), {i_ack, d_ack, i_err, d_err},
                  vecs[v].expv[3:0]);
      checkOutput($sformatf("vec%0d_rdat", v), i_rdat, vecs[v].rdat);
      stepClock();
    end

    // tie after reset: data master first, then instruction with no gap
    resetDut();
    setMaster(0, 32'h200, 32'h0, 1'b0);
    setMaster(1, 32'h400, 32'h55AA, 1'b1);
    applyStimulus(6'b111100, 32'h0);
    checkOutput("tie_idle_cyc", w_cyc, 1'b0);
    stepClock();
    applyStimulus(6'b111100, 32'h0);
    checkOutput("tie_d_cyc", w_cyc, 1'b1);
    checkOutput("tie_d_addr", w_addr, 32'h400);
    checkOutput("tie_d_we", w_we, 1'b1);
    checkOutput("tie_d_wdat", w_wdat, 32'h55AA);
    stepClock();
    applyStimulus(6'b111110, 32'h0);
    checkOutput("tie_d_ack", {i_ack, d_ack}, 2'b01);
    stepClock();
    applyStimulus(6'b110000, 32'h0);
    checkOutput("tie_drop_cyc", w_cyc, 1'b0);
    stepClock();
    applyStimulus(6'b110000, 32'h0);
    checkOutput("tie_i_cyc", w_cyc, 1'b1);
    checkOutput("tie_i_addr", w_addr, 32'h200);
    checkOutput("tie_i_we", w_we, 1'b0);
    stepClock();
    applyStimulus(6'b110010, 32'h0);
    checkOutput("tie_i_ack", {i_ack, d_ack}, 2'b10);
    stepClock();
    applyStimulus(6'b000000, 32'h0);
    stepClock();

    // grant hold: four data beats in one cycle while I waits
    applyStimulus(6'b111100, 32'h0);
    stepClock();
    for (int b = 0; b < 4; b++) begin
      applyStimulus(6'b111110, 32'h0);
      checkOutput($sformatf("hold_beat%0d_addr", b), w_addr, 32'h400);
      checkOutput($sformatf("hold_beat%0d_ack", b), {i_ack, d_ack}, 2'b01);
      stepClock();
      applyStimulus(6'b111000, 32'h0);
      checkOutput($sformatf("hold_gap%0d_cycstb", b), {w_cyc, w_stb}, 2'b10);
      checkOutput($sformatf("hold_gap%0d_addr", b), w_addr, 32'h400);
      stepClock();
    end
    applyStimulus(6'b110000, 32'h0);
    checkOutput("hold_release_addr", w_addr, 32'h400);
    stepClock();
    applyStimulus(6'b110000, 32'h0);
    checkOutput("hold_i_addr", w_addr, 32'h200);
    checkOutput("hold_i_cyc", w_cyc, 1'b1);
    stepClock();
    applyStimulus(6'b000000, 32'h0);
    stepClock();

    // watchdog: slave never answers the instruction master
    resetDut();
    setMaster(0, 32'h300, 32'h0, 1'b0);
    applyStimulus(6'b110000, 32'h0);
    stepClock();
    for (int k = 1; k <= TIMEOUT; k++) begin
      applyStimulus(6'b110000, 32'h0);
      checkOutput($sformatf("wd_wait%0d", k), {w_cyc, i_err, w_timeout}, 3'b100);
      stepClock();
    end
    applyStimulus(6'b110010, 32'h0);
    checkOutput("wd_fire_err", i_err, 1'b1);
    checkOutput("wd_fire_timeout", w_timeout, 1'b1);
    checkOutput("wd_fire_late_ack", i_ack, 1'b0);
    checkOutput("wd_fire_cycstb", {w_cyc, w_stb}, 2'b00);
    checkOutput("wd_fire_derr", d_err, 1'b0);
    stepClock();
    applyStimulus(6'b110000, 32'h0);
    checkOutput("wd_after", {w_cyc, i_err, w_timeout}, 3'b000);
    stepClock();
    applyStimulus(6'b110000, 32'h0);
    checkOutput("wd_regrant_cyc", w_cyc, 1'b1);
    stepClock();
    applyStimulus(6'b000000, 32'h0);
    stepClock();

    // reset during a data grant when the data master won last
    resetDut();
    setMaster(0, 32'h200, 32'h0, 1'b0);
    setMaster(1, 32'h400, 32'h55AA, 1'b1);
    applyStimulus(6'b001100, 32'h0);
    stepClock();
    applyStimulus(6'b001110, 32'h0);
    stepClock();
    applyStimulus(6'b000000, 32'h0);
    stepClock();
    applyStimulus(6'b001100, 32'h0);
    stepClock();
    applyStimulus(6'b001100, 32'h0);
    checkOutput("rstmid_pre_addr", w_addr, 32'h400);
    stepClock();
    rst = 1'b1;
    applyStimulus(6'b001110, 32'h0);
    stepClock();
    rst = 1'b0;
    applyStimulus(6'b111110, 32'h0);
    checkOutput("rstmid_cyc", w_cyc, 1'b0);
    checkOutput("rstmid_addr", w_addr, 32'h0);
    checkOutput("rstmid_ack", {i_ack, d_ack, w_timeout}, 3'b000);
    stepClock();
    applyStimulus(6'b111100, 32'h0);
    checkOutput("rstmid_tie_addr", w_addr, 32'h400);
    stepClock();
    applyStimulus(6'b000000, 32'h0);
    stepClock();

    // randomized traffic against the model
    resetDut();
    mdl_owner = -1; mdl_last = 0; mdl_wait = 0; mdl_term = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (m_cyc[m]) begin
          if ($urandom_range(3) == 0) m_cyc[m] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          m_cyc[m] = 1'b1;
        end
        m_stb[m]  = m_cyc[m] & ($urandom_range(3) != 0);
        m_addr[m] = $urandom;
        m_wdat[m] = $urandom;
        m_we[m]   = 1'($urandom_range(1));
        m_sel[m]  = 4'($urandom_range(15));
      end
      sl_ack  = (((c / 64) % 2) == 0) && ($urandom_range(2) == 0);
      sl_err  = ($urandom_range(15) == 0);
      sl_rdat = $urandom;
      rst     = ($urandom_range(299) == 0);
      #1;
      modelCheck();
      stepClock();
      modelStep();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
